shared_unit_arbiter: RTL and testbench

Round-robin arbiter and sequencer that time-shares one 2-bit compute instance (in0/in1/out bus datapath, same shape as the module2 tiles) among NUM_REQ requesters.
Accepts one operand pair per transaction, drives the shared unit, waits its fixed latency, then returns the result tagged with the requester ID.
Sits beside the shared tile in the top-level grid, replacing duplicated per-requester instances.

---
 rtl/shared_unit_arbiter.sv | 138 +++++++++++++
 tb/tb_shared_unit_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/shared_unit_arbiter.sv
// Round-robin arbiter/sequencer time-sharing one fixed-latency compute unit among NUM_REQ requesters.
// Result appears UNIT_LAT+1 cycles after acceptance; requesters stall until the result is taken. Optional ARB_LOCK_EN adds sticky grants.
module shared_unit_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 2,
    parameter int UNIT_LAT = 1,
    parameter int ID_W     = 2,
    parameter int LOCK_MAX = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_in0,
    input  logic [NUM_REQ*DATA_W-1:0] req_in1,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [DATA_W-1:0]         unit_in0,
    output logic [DATA_W-1:0]         unit_in1,
    output logic                      unit_busy,
    input  logic [DATA_W-1:0]         unit_out,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ID_W-1:0]           res_id,
    output logic [DATA_W-1:0]         res_data
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (UNIT_LAT < 1) ? 1 : $clog2(UNIT_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_id;
    logic [CNT_W-1:0]   counter;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   ptr_adv;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(idx);
            end
        end
    end

    assign ptr_adv = (gnt_id == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_id + PTR_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_found) state_next = WAIT;
            WAIT:    if (counter == '0) state_next = RESP;
            RESP:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // req_ready is masked during reset so nothing looks accepted while state is forced.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_found && !reset) req_ready[win_idx] = 1'b1;
        unit_busy = (state == WAIT);
        res_valid = (state == RESP);
    end

`ifdef ARB_LOCK_EN
    localparam int LCK_W = $clog2(LOCK_MAX + 1);
    logic [LCK_W-1:0] lock_cnt;
    logic             lock_hold;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr    <= '0;
            gnt_id    <= '0;
            counter   <= '0;
            unit_in0  <= '0;
            unit_in1  <= '0;
            res_id    <= '0;
            res_data  <= '0;
`ifdef ARB_LOCK_EN
            lock_cnt  <= '0;
            lock_hold <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (win_found) begin
                    unit_in0  <= req_in0[win_idx*DATA_W +: DATA_W];
                    unit_in1  <= req_in1[win_idx*DATA_W +: DATA_W];
                    gnt_id    <= win_idx;
                    counter   <= CNT_W'(UNIT_LAT);
`ifdef ARB_LOCK_EN
                    lock_hold <= req_lock[win_idx];
`endif
                end
                WAIT: if (counter == '0) begin
                    res_data <= unit_out;
                    res_id   <= ID_W'(gnt_id);
                end else begin
                    counter  <= counter - CNT_W'(1);
                end
                RESP: if (res_ready) begin
`ifdef ARB_LOCK_EN
                    // lock_cnt counts grants already taken in the current locked run.
                    if (lock_hold && (int'(lock_cnt) + 1 < LOCK_MAX)) begin
                        rr_ptr   <= gnt_id;
                        lock_cnt <= lock_cnt + LCK_W'(1);
                    end else begin
                        rr_ptr   <= ptr_adv;
                        lock_cnt <= '0;
                    end
`else
                    rr_ptr <= ptr_adv;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Directed bench for shared_unit_arbiter at default parameters, with an XOR model unit registered once.
module tb_shared_unit_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [7:0] req_in0;
    logic [7:0] req_in1;
    logic [3:0] req_lock;
    logic [1:0] unit_in0;
    logic [1:0] unit_in1;
    logic       unit_busy;
    logic [1:0] unit_out;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_id;
    logic [1:0] res_data;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) unit_out <= unit_in0 ^ unit_in1;

    shared_unit_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in0   (req_in0),
        .req_in1   (req_in1),
`ifdef ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .unit_in0  (unit_in0),
        .unit_in1  (unit_in1),
        .unit_busy (unit_busy),
        .unit_out  (unit_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester i has in0=i, in1=3, so its result is 3-i.
    task automatic expect_grant(input int id);
        int n;
        chk("grant", 32'(req_ready), 1 << id);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!res_valid && n < 8);
        chk("latency", n, 3);
        chk("res_id", 32'(res_id), id);
        chk("res_data", 32'(res_data), 3 - id);
        chk("ready_in_resp", 32'(req_ready), 0);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_lock  = 4'b0000;
        req_in0   = {2'b11, 2'b10, 2'b01, 2'b00};
        req_in1   = {2'b11, 2'b11, 2'b11, 2'b11};
        res_ready = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_unit_in0", 32'(unit_in0), 0);
        chk("rst_unit_in1", 32'(unit_in1), 0);
        chk("rst_unit_busy", 32'(unit_busy), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_res_data", 32'(res_data), 0);

        @(negedge clk); reset = 1'b0; #1;
        chk("idle_no_valid", 32'(req_ready), 0);

        // Single request from requester 2, then hold the result under backpressure.
        @(negedge clk); req_valid = 4'b0100; #1;
        chk("single_grant", 32'(req_ready), 4'b0100);
        chk("single_not_busy", 32'(unit_busy), 0);
        @(negedge clk); req_valid = 4'b1111; #1;
        chk("wait_ready", 32'(req_ready), 0);
        chk("wait_busy", 32'(unit_busy), 1);
        chk("wait_in0", 32'(unit_in0), 2'b10);
        chk("wait_in1", 32'(unit_in1), 2'b11);
        chk("wait_no_res", 32'(res_valid), 0);
        @(negedge clk); #1;
        chk("wait2_busy", 32'(unit_busy), 1);
        chk("wait2_no_res", 32'(res_valid), 0);
        @(negedge clk); #1;
        chk("resp_valid", 32'(res_valid), 1);
        chk("resp_id", 32'(res_id), 2);
        chk("resp_data", 32'(res_data), 2'b01);
        chk("resp_not_busy", 32'(unit_busy), 0);
        repeat (5) begin
            @(negedge clk); #1;
            chk("bp_valid", 32'(res_valid), 1);
            chk("bp_id", 32'(res_id), 2);
            chk("bp_data", 32'(res_data), 2'b01);
            chk("bp_ready", 32'(req_ready), 0);
        end
        @(negedge clk); res_ready = 1'b1; #1;
        chk("hs_valid", 32'(res_valid), 1);

        // All four continuously valid: rotation resumes after requester 2.
        @(negedge clk); #1; expect_grant(3);
        @(negedge clk); #1; expect_grant(0);
        @(negedge clk); #1; expect_grant(1);
        @(negedge clk); #1; expect_grant(2);
        @(negedge clk); #1; expect_grant(3);
        @(negedge clk); #1; expect_grant(0);

        // Sparse requests: bring rr_ptr to 3, then 0 and 1 must be served in wrap order.
        @(negedge clk); req_valid = 4'b0100; #1; expect_grant(2);
        @(negedge clk); req_valid = 4'b0011; #1; expect_grant(0);
        @(negedge clk); #1; expect_grant(1);

        // Reset in the middle of WAIT drops the transaction.
        @(negedge clk); req_valid = 4'b1000; #1;
        chk("pre_rst_grant", 32'(req_ready), 4'b1000);
        @(negedge clk); reset = 1'b1; req_valid = 4'b0001; #1;
        chk("mid_rst_ready", 32'(req_ready), 0);
        chk("mid_rst_in0", 32'(unit_in0), 0);
        chk("mid_rst_in1", 32'(unit_in1), 0);
        chk("mid_rst_busy", 32'(unit_busy), 0);
        chk("mid_rst_res_valid", 32'(res_valid), 0);
        chk("mid_rst_res_id", 32'(res_id), 0);
        chk("mid_rst_res_data", 32'(res_data), 0);
        @(negedge clk); reset = 1'b0; #1;
        expect_grant(0);

`ifdef ARB_LOCK_EN
        // Requester 1 locked: four consecutive grants, then rotation continues.
        @(negedge clk); req_valid = 4'b1111; req_lock = 4'b0010; #1; expect_grant(1);
        @(negedge clk); #1; expect_grant(1);
        @(negedge clk); #1; expect_grant(1);
        @(negedge clk); #1; expect_grant(1);
        @(negedge clk); #1; expect_grant(2);
        @(negedge clk); #1; expect_grant(3);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
